// File: rtl/xeng_acc_ctrl_if.sv
// rtl/xeng_acc_ctrl_if.sv - loader/order-generator/readout handshake bundle; XENG_ACC_CTRL_OVF_CNT_EN adds ovf_cnt
interface xeng_acc_ctrl_if;
  logic        sync_in;
  logic        load_done;
  logic        load_ready;
  logic        bl_sync;
  logic        bl_en;
  logic        rd_buf;
  logic        acc_first;
  logic        acc_last;
  logic        dump_req;
  logic        dump_ack;
  logic        ovf;
`ifdef XENG_ACC_CTRL_OVF_CNT_EN
  logic [15:0] ovf_cnt;

  modport master (
    output sync_in, load_done, dump_ack,
    input  load_ready, bl_sync, bl_en, rd_buf, acc_first, acc_last, dump_req, ovf, ovf_cnt
  );
  modport slave (
    input  sync_in, load_done, dump_ack,
    output load_ready, bl_sync, bl_en, rd_buf, acc_first, acc_last, dump_req, ovf, ovf_cnt
  );
`else
  modport master (
    output sync_in, load_done, dump_ack,
    input  load_ready, bl_sync, bl_en, rd_buf, acc_first, acc_last, dump_req, ovf
  );
  modport slave (
    input  sync_in, load_done, dump_ack,
    output load_ready, bl_sync, bl_en, rd_buf, acc_first, acc_last, dump_req, ovf
  );
`endif
endinterface

// File: rtl/xeng_acc_ctrl.sv
// rtl/xeng_acc_ctrl.sv - X-engine pass/integration sequencer; XENG_ACC_CTRL_OVF_CNT_EN adds saturating ovf_cnt
module xeng_acc_ctrl #(
  parameter int N_ANTS  = 16,
  parameter int ACC_LEN = 64
) (
  input logic            clk,
  input logic            rstn,
  xeng_acc_ctrl_if.slave bus
);
  localparam int BL_PER_PASS = N_ANTS * (N_ANTS / 2 + 1);
  localparam int BW = $clog2(BL_PER_PASS);
  localparam int PW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [BW-1:0] BL_LAST   = BW'(BL_PER_PASS - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(ACC_LEN - 1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, DUMP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    pend_q, pend_d;
  logic [BW-1:0] bl_cnt_q, bl_cnt_d;
  logic [PW-1:0] pass_cnt_q, pass_cnt_d;
  logic          aligned_q, aligned_d;
  logic          rd_buf_q, rd_buf_d;
  logic          ovf_q, ovf_d;

  logic pass_end;
  logic load_take;
  logic load_drop;

  assign pass_end  = (state_q == RUN) && (bl_cnt_q == BL_LAST);
  assign load_take = bus.load_done && (pend_q != 2'd2);
  assign load_drop = bus.load_done && (pend_q == 2'd2);

  // Next-state: buffer bookkeeping, pass/integration sequencing, sync_in abort on top
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    bl_cnt_d   = bl_cnt_q;
    pass_cnt_d = pass_cnt_q;
    aligned_d  = aligned_q;
    rd_buf_d   = rd_buf_q;
    ovf_d      = ovf_q | load_drop;

    // A drop still lets a finishing pass consume its buffer
    case ({load_take, pass_end})
      2'b10:   pend_d = pend_q + 2'd1;
      2'b01:   pend_d = pend_q - 2'd1;
      default: pend_d = pend_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pend_q != 2'd0) state_d = aligned_q ? RUN : SYNC;
      end
      SYNC: begin
        aligned_d  = 1'b1;
        pass_cnt_d = '0;
        rd_buf_d   = 1'b0;
        bl_cnt_d   = '0;
        state_d    = RUN;
      end
      RUN: begin
        if (pass_end) begin
          rd_buf_d = ~rd_buf_q;
          bl_cnt_d = '0;
          if (pass_cnt_q == PASS_LAST) begin
            pass_cnt_d = '0;
            state_d    = DUMP;
          end else begin
            pass_cnt_d = pass_cnt_q + PW'(1);
            state_d    = (pend_d != 2'd0) ? RUN : IDLE;
          end
        end else begin
          bl_cnt_d = bl_cnt_q + BW'(1);
        end
      end
      DUMP: begin
        if (bus.dump_ack) state_d = (pend_q != 2'd0) ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Realign: drop all pending work, keep the sticky overflow history
    if (bus.sync_in) begin
      state_d    = IDLE;
      pend_d     = 2'd0;
      bl_cnt_d   = '0;
      pass_cnt_d = '0;
      aligned_d  = 1'b0;
      rd_buf_d   = 1'b0;
      ovf_d      = ovf_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      pend_q     <= 2'd0;
      bl_cnt_q   <= '0;
      pass_cnt_q <= '0;
      aligned_q  <= 1'b0;
      rd_buf_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      bl_cnt_q   <= bl_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      aligned_q  <= aligned_d;
      rd_buf_q   <= rd_buf_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.load_ready = (pend_q != 2'd2);
  assign bus.bl_sync    = (state_q == SYNC);
  assign bus.bl_en      = (state_q == RUN);
  assign bus.rd_buf     = rd_buf_q;
  assign bus.acc_first  = (state_q == RUN) && (pass_cnt_q == '0);
  assign bus.acc_last   = (state_q == RUN) && (pass_cnt_q == PASS_LAST);
  assign bus.dump_req   = (state_q == DUMP);
  assign bus.ovf        = ovf_q;

`ifdef XENG_ACC_CTRL_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of dropped loads; a load coinciding with sync_in is not a drop
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (load_drop && !bus.sync_in && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  // Drop counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) ovf_cnt_q <= 16'd0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign bus.ovf_cnt = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_xeng_acc_ctrl.sv
// tb/tb_xeng_acc_ctrl.sv - self-checking bench for xeng_acc_ctrl (N_ANTS=16, ACC_LEN=4)
module tb_xeng_acc_ctrl;
  logic clk;
  logic rstn;
  xeng_acc_ctrl_if bus();

  xeng_acc_ctrl #(.N_ANTS(16), .ACC_LEN(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int nload; int gap; int n_en; int n_rise; int last_off;
    int n_first; int n_last; int n_dump; int n_rd1; int ovf;
  } vec_t;
  vec_t vecs[6];

  int total = 0;
  int bad = 0;
  int n_en, n_rise, en_first, en_last, n_first, n_last, n_sync, n_dump, n_dump_cyc, n_rd1, hold;
  bit prev_en, prev_dump, auto_ack;
  int sync_q[$];
  int t0, n;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.load_ready, bus.bl_sync, bus.bl_en, bus.rd_buf,
                 bus.acc_first, bus.acc_last, bus.dump_req, bus.ovf});
  endfunction

  task automatic clear_mon();
    n_en = 0; n_rise = 0; en_first = -1; en_last = -1; n_first = 0; n_last = 0;
    n_sync = 0; n_dump = 0; n_dump_cyc = 0; n_rd1 = 0;
  endtask

  // Sample the current cycle, score bl_sync against expectations, optionally ack dumps, advance
  task automatic tick();
    int e;
    if (bus.bl_en) begin
      n_en++;
      if (!prev_en) begin
        n_rise++;
        if (en_first < 0) en_first = cyc;
      end
      en_last = cyc;
      if (bus.rd_buf) n_rd1++;
    end
    if (bus.acc_first) n_first++;
    if (bus.acc_last) n_last++;
    if (bus.bl_sync) begin
      n_sync++;
      if (sync_q.size() == 0) chk("unexpected_bl_sync", cyc, -1);
      else begin
        e = sync_q.pop_front();
        chk("bl_sync_cycle", cyc, e);
      end
    end
    if (bus.dump_req) begin
      n_dump_cyc++;
      if (!prev_dump) n_dump++;
      hold++;
      if (auto_ack && hold == 5) bus.dump_ack = 1'b1;
    end
    prev_en = bus.bl_en;
    prev_dump = bus.dump_req;
    @(posedge clk);
    #1;
    if (bus.dump_ack) hold = 0;
    bus.load_done = 1'b0;
    bus.sync_in = 1'b0;
    bus.dump_ack = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sync_q.delete();
    tick();
    tick();
    rstn = 1'b1;
    hold = 0;
  endtask

  task automatic drain(input int cap);
    int quiet = 0;
    int k = 0;
    while (quiet < 20 && k < cap) begin
      tick();
      k++;
      quiet = (!bus.bl_en && !bus.dump_req && !bus.bl_sync) ? quiet + 1 : 0;
    end
    if (k >= cap) chk("drain_timeout", k, 0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.load_done = 1'b0;
    bus.sync_in = 1'b0;
    bus.dump_ack = 1'b0;
    auto_ack = 1'b1;
    hold = 0;
    prev_en = 1'b0;
    prev_dump = 1'b0;
    clear_mon();
    // nload, gap, en cycles, en rises, last en offset, acc_first, acc_last, dumps, rd_buf=1 en cycles, ovf
    vecs[0] = '{1,   1,  144, 1,  146, 144,   0, 0,   0, 0};
    vecs[1] = '{2,  10,  288, 1,  290, 144,   0, 0, 144, 0};
    vecs[2] = '{3,  10,  288, 1,  290, 144,   0, 0, 144, 1};
    vecs[3] = '{3, 200,  432, 3,  545, 144,   0, 0, 144, 0};
    vecs[4] = '{4, 100,  576, 1,  578, 144, 144, 1, 288, 0};
    vecs[5] = '{8, 144, 1152, 2, 1159, 288, 288, 2, 576, 0};
    @(posedge clk);
    #1;

    for (int r = 0; r < 6; r++) begin
      do_reset();
      chk($sformatf("row%0d_reset_outs", r), outs(), 8'h80);
`ifdef XENG_ACC_CTRL_OVF_CNT_EN
      chk($sformatf("row%0d_reset_ovf_cnt", r), int'(bus.ovf_cnt), 0);
`endif
      clear_mon();
      t0 = cyc;
      for (int k = 0; k < vecs[r].nload; k++) begin
        bus.load_done = 1'b1;
        if (k == 0) sync_q.push_back(cyc + 2);
        tick();
        for (int g = 1; g < vecs[r].gap; g++) tick();
      end
      drain(3000);
      chk($sformatf("row%0d_en_cycles", r), n_en, vecs[r].n_en);
      chk($sformatf("row%0d_en_rises", r), n_rise, vecs[r].n_rise);
      chk($sformatf("row%0d_en_first", r), en_first - t0, 3);
      chk($sformatf("row%0d_en_last", r), en_last - t0, vecs[r].last_off);
      chk($sformatf("row%0d_syncs", r), n_sync, 1);
      chk($sformatf("row%0d_acc_first", r), n_first, vecs[r].n_first);
      chk($sformatf("row%0d_acc_last", r), n_last, vecs[r].n_last);
      chk($sformatf("row%0d_dumps", r), n_dump, vecs[r].n_dump);
      chk($sformatf("row%0d_dump_cycles", r), n_dump_cyc, 5 * vecs[r].n_dump);
      chk($sformatf("row%0d_rd_buf1", r), n_rd1, vecs[r].n_rd1);
      chk($sformatf("row%0d_ovf", r), int'(bus.ovf), vecs[r].ovf);
      chk($sformatf("row%0d_load_ready", r), int'(bus.load_ready), 1);
      chk($sformatf("row%0d_sync_left", r), sync_q.size(), 0);
`ifdef XENG_ACC_CTRL_OVF_CNT_EN
      chk($sformatf("row%0d_ovf_cnt", r), int'(bus.ovf_cnt), vecs[r].ovf);
`endif
    end

    // Overflow with load_ready timing, then sync_in mid-RUN with a same-cycle load
    do_reset();
    clear_mon();
    t0 = cyc;
    bus.load_done = 1'b1;
    sync_q.push_back(cyc + 2);
    tick();
    repeat (9) tick();
    bus.load_done = 1'b1;
    tick();
    chk("ovf_pend2_load_ready", int'(bus.load_ready), 0);
    chk("ovf_before_drop", int'(bus.ovf), 0);
    repeat (9) tick();
    bus.load_done = 1'b1;
    tick();
    chk("ovf_after_drop", int'(bus.ovf), 1);
    chk("ovf_drop_load_ready", int'(bus.load_ready), 0);
`ifdef XENG_ACC_CTRL_OVF_CNT_EN
    chk("ovf_cnt_after_drop", int'(bus.ovf_cnt), 1);
`endif
    while (cyc < t0 + 146) tick();
    chk("load_ready_last_run", int'(bus.load_ready), 0);
    tick();
    chk("load_ready_after_pass", int'(bus.load_ready), 1);
    chk("back_to_back_en", int'(bus.bl_en), 1);
    chk("second_pass_rd_buf", int'(bus.rd_buf), 1);
    while (cyc < t0 + 200) tick();
    bus.sync_in = 1'b1;
    bus.load_done = 1'b1;
    tick();
    chk("sync_in_outs", outs(), 8'h81);
`ifdef XENG_ACC_CTRL_OVF_CNT_EN
    chk("sync_in_ovf_cnt", int'(bus.ovf_cnt), 1);
`endif
    clear_mon();
    repeat (10) tick();
    chk("sync_in_quiet_en", n_en, 0);
    chk("sync_in_quiet_sync", n_sync, 0);
    clear_mon();
    t0 = cyc;
    bus.load_done = 1'b1;
    sync_q.push_back(cyc + 2);
    tick();
    drain(1000);
    chk("resync_en_first", en_first - t0, 3);
    chk("resync_en_cycles", n_en, 144);
    chk("resync_acc_first", n_first, 144);
    chk("resync_rd_buf1", n_rd1, 0);
    chk("resync_syncs", n_sync, 1);
    chk("resync_ovf_kept", int'(bus.ovf), 1);

    // Reset while a dump is pending; later acks must be ignored
    do_reset();
    clear_mon();
    auto_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.load_done = 1'b1;
      if (k == 0) sync_q.push_back(cyc + 2);
      tick();
      repeat (99) tick();
    end
    n = 0;
    while (!bus.dump_req && n < 2000) begin
      tick();
      n++;
    end
    chk("dump_reached", int'(bus.dump_req), 1);
    tick();
    tick();
    chk("dump_held_no_ack", int'(bus.dump_req), 1);
    rstn = 1'b0;
    tick();
    chk("reset_in_dump_outs", outs(), 8'h80);
`ifdef XENG_ACC_CTRL_OVF_CNT_EN
    chk("reset_in_dump_ovf_cnt", int'(bus.ovf_cnt), 0);
`endif
    rstn = 1'b1;
    clear_mon();
    repeat (4) begin
      bus.dump_ack = 1'b1;
      tick();
    end
    chk("stray_ack_outs", outs(), 8'h80);
    chk("stray_ack_en", n_en, 0);
    chk("stray_ack_dump", n_dump_cyc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xeng_acc_ctrl.md
# xeng_acc_ctrl

Sequencing controller for the X-engine baseline order generator and its accumulator. It tracks antenna-sample buffers loaded by the upstream loader and starts one full baseline pass per loaded buffer. It also counts passes per integration, flags the first and last pass to the accumulator, and holds the dump handshake with the readout stage. It sits between the sample-buffer loader and `bl_order_gen`, driving that block's `sync` and `en` inputs.

## Interface
- `N_ANTS`, 16, antennas; power of two, ≥4
- `ACC_LEN`, 64, passes (spectra) per integration; ≥1
- `BL_PER_PASS` (localparam), N_ANTS*(N_ANTS/2+1), cycles per baseline pass (144 at N_ANTS=16)
- `clk` in 1 — single clock, all logic on rising edge
- `rstn` in 1 — synchronous, active-low reset
- `sync_in` in 1 — integration realign/abort pulse
- `load_done` in 1 — one-cycle pulse: one antenna buffer fully loaded
- `load_ready` out 1 — pending-buffer slot free (`pend != 2`)
- `bl_sync` out 1 — to order generator `sync`
- `bl_en` out 1 — to order generator `en`
- `rd_buf` out 1 — buffer index read by the current pass
- `acc_first` out 1 — current pass is first of integration (accumulator loads, not adds)
- `acc_last` out 1 — current pass is last of integration
- `dump_req` out 1 — integration complete, accumulator readable
- `dump_ack` in 1 — readout done
- `ovf` out 1 — sticky: `load_done` dropped
- `ovf_cnt` out 16 — only with `XENG_ACC_CTRL_OVF_CNT_EN`

## Operation
- Internal registers:
  - `pend` (0..2): loaded, unprocessed buffers
  - `bl_cnt` (0..BL_PER_PASS-1)
  - `pass_cnt` (0..ACC_LEN-1)
  - `aligned` flag
- `pend` update:
  - `load_done` with `pend<2` increments it.
  - The last RUN cycle (`bl_cnt==BL_PER_PASS-1`) decrements it.
  - Both in the same cycle leave it unchanged.
  - `load_done` with `pend==2` is dropped and sets `ovf`, even if a pass ends in that cycle.
- FSM states IDLE, SYNC, RUN, DUMP:
  - IDLE: if `pend>0`, go to RUN when `aligned`, otherwise to SYNC.
  - SYNC: `bl_sync=1` for exactly one cycle; set `aligned=1`, `pass_cnt=0`, `rd_buf=0`, `bl_cnt=0`; go to RUN.
  - RUN: `bl_en=1` every cycle and `bl_cnt` increments. On the last cycle: toggle `rd_buf`, `bl_cnt←0`. Then, in priority order:
    - if `pass_cnt==ACC_LEN-1`: `pass_cnt←0`, go to DUMP;
    - else if `pend` after decrement >0: `pass_cnt++`, stay in RUN back-to-back with no gap cycle;
    - else `pass_cnt++`, go to IDLE.
  - DUMP: `dump_req=1` until a cycle with `dump_ack=1`. In that cycle `dump_req` drops and the state goes to RUN if `pend>0`, otherwise IDLE. Loads are accepted during DUMP. `dump_ack` outside DUMP is ignored.
- `acc_first` = RUN && `pass_cnt==0`; `acc_last` = RUN && `pass_cnt==ACC_LEN-1`. With `ACC_LEN==1` both are high on every pass.
- `bl_sync` is issued only on the first pass after reset or `sync_in`, never between passes. The order generator wraps cleanly every BL_PER_PASS enables.
- `sync_in`, in any state, has priority over everything:
  - state←IDLE, `aligned←0`, `pend←0`, `pass_cnt←0`, `bl_cnt←0`, `rd_buf←0`, `dump_req←0`
  - a same-cycle `load_done` is discarded without setting `ovf`
  - `ovf` is kept
- Reset values: state IDLE, all counters 0, `aligned=0`. Outputs: `load_ready=1`; `bl_sync`, `bl_en`, `rd_buf`, `acc_first`, `acc_last`, `dump_req`, `ovf` all 0; `ovf_cnt=0`.
- `ovf` clears only on `rstn`.

## Timing
- All outputs are registered, or decoded combinationally from registered state only. There are no combinational input-to-output paths.
- `load_done` at cycle t into IDLE:
  - if aligned: `bl_en` high from t+2;
  - if unaligned: `bl_sync` at t+2, `bl_en` from t+3.
- RUN lasts exactly BL_PER_PASS cycles per pass. `bl_en` is continuous across back-to-back passes.
- `dump_req` rises in the cycle after the last RUN cycle of the integration.
- `load_ready` reflects `pend` of the current cycle.

## Configuration
- `XENG_ACC_CTRL_OVF_CNT_EN` defined:
  - adds port `ovf_cnt`, a 16-bit count of dropped `load_done` pulses;
  - it saturates at 0xFFFF and clears on `rstn` only.
- Undefined: the port and counter are absent; only the sticky `ovf` is present.

## Test plan
All scenarios use N_ANTS=16 (BL_PER_PASS=144) and ACC_LEN=4.
- Reset, then `load_done` at t → `bl_sync` exactly at t+2; `bl_en` high t+3..t+146; `acc_first=1` throughout; `rd_buf=0`; then IDLE with `load_ready=1`.
- Two pulses 10 cycles apart → 288 contiguous `bl_en` cycles, one `bl_sync`, `rd_buf` 0 then 1.
- Eight loads keeping `pend≥1`:
  - `dump_req` after pass 4, held 5 cycles until `dump_ack`, RUN resumes in the ack cycle+1;
  - `acc_last` high only on passes 4 and 8.
- Three `load_done` before the first pass ends → third dropped, `ovf=1`, `load_ready=0` while `pend==2`, `ovf_cnt=1` if enabled.
- `sync_in` mid-RUN with same-cycle `load_done` → `bl_en=0` next cycle, `pend=0`, `ovf` unchanged. Next load produces a fresh `bl_sync` and `acc_first=1`.
- `rstn=0` during DUMP → all outputs at reset values on the following cycle; `dump_ack` afterwards is ignored.
